// File: rtl/pattern_101_tx_if.sv
// rtl/pattern_101_tx_if.sv - word-in / serial-out bus bundle for the 101-framed transmitter
interface pattern_101_tx_if #(
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              tx_bit;
    logic              tx_active;
    logic              frame_done;

    // Word source and line observer
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  tx_bit,
        input  tx_active,
        input  frame_done
    );

    // Transmitter side
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output tx_bit,
        output tx_active,
        output frame_done
    );
endinterface

// File: rtl/pattern_101_tx.sv
// rtl/pattern_101_tx.sv - framed serial transmitter: 1-0-1 preamble, MSB-first payload, even parity, idle gap
module pattern_101_tx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int GAP_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    pattern_101_tx_if.slave bus
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_PAR  = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    // The state names the bit currently on the line; the _d values are what the
    // line carries in the next cycle, so every output is a plain register.
    logic [2:0]        state_q,      state_d;
    logic [1:0]        pre_cnt_q,    pre_cnt_d;
    logic [CW-1:0]     bit_cnt_q,    bit_cnt_d;
    logic [GW-1:0]     gap_cnt_q,    gap_cnt_d;
    logic [DATA_W-1:0] shreg_q,      shreg_d;
    logic              par_q,        par_d;
    logic              tx_bit_q,     tx_bit_d;
    logic              tx_active_q,  tx_active_d;
    logic              frame_done_q, frame_done_d;

    // Next-state and next-line-bit selection for the frame sequencer
    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        tx_bit_d     = 1'b0;
        tx_active_d  = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    shreg_d     = bus.in_data;
                    par_d       = ^bus.in_data;
                    state_d     = ST_PRE;
                    pre_cnt_d   = 2'd0;
                    tx_bit_d    = 1'b1;
                    tx_active_d = 1'b1;
                end
            end

            ST_PRE: begin
                tx_active_d = 1'b1;
                if (pre_cnt_q != 2'd2) begin
                    // Line shows 1 at count 0 and 0 at count 1; the following bit flips it.
                    pre_cnt_d = pre_cnt_q + 2'd1;
                    tx_bit_d  = (pre_cnt_q == 2'd1);
                end else begin
                    pre_cnt_d    = 2'd0;
                    bit_cnt_d    = '0;
                    state_d      = ST_DATA;
                    tx_bit_d     = shreg_q[DATA_W-1];
                    shreg_d      = shreg_q << 1;
                    frame_done_d = (DATA_W == 1) && (PARITY_EN == 0);
                end
            end

            ST_DATA: begin
                if (bit_cnt_q != CW'(DATA_W - 1)) begin
                    bit_cnt_d    = bit_cnt_q + CW'(1);
                    tx_active_d  = 1'b1;
                    tx_bit_d     = shreg_q[DATA_W-1];
                    shreg_d      = shreg_q << 1;
                    frame_done_d = (PARITY_EN == 0) && (bit_cnt_q == CW'(DATA_W - 2));
                end else begin
                    bit_cnt_d = '0;
                    if (PARITY_EN != 0) begin
                        state_d      = ST_PAR;
                        tx_bit_d     = par_q;
                        tx_active_d  = 1'b1;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                        gap_cnt_d = '0;
                    end
                end
            end

            ST_PAR: begin
                state_d   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                gap_cnt_d = '0;
            end

            ST_GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters, payload and line registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pre_cnt_q    <= 2'd0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            tx_bit_q     <= 1'b0;
            tx_active_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            tx_bit_q     <= tx_bit_d;
            tx_active_q  <= tx_active_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.tx_bit     = tx_bit_q;
    assign bus.tx_active  = tx_active_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_pattern_101_tx.sv
// tb/tb_pattern_101_tx.sv - directed and random frame checks against a frame-level model
module tb_pattern_101_tx;
    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pattern_101_tx_if #(.DATA_W(8)) bus_a ();
    pattern_101_tx_if #(.DATA_W(4)) bus_b ();

    pattern_101_tx #(.DATA_W(8), .PARITY_EN(1), .GAP_CYCLES(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    pattern_101_tx #(.DATA_W(4), .PARITY_EN(0), .GAP_CYCLES(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // Overlapping Moore 101 detector fed from dut_a's line
    logic [2:0] hist = 3'b000;
    logic       det  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        det  = (hist == 3'b101);
        hist = {hist[1:0], bus_a.tx_bit};
    endtask

    // Whole frame as a bit string, first transmitted bit in the MSB
    function automatic logic [11:0] frame_of(input logic [7:0] w);
        logic p;
        p = ($countones(w) % 2) == 1;
        return {3'b101, w, p};
    endfunction

    task automatic do_frame(input logic [7:0] w, input bit hold);
        logic [11:0] fr;
        fr = frame_of(w);
        chk("accept_ready", bus_a.in_ready, 1);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = w;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 1) bus_a.in_valid = hold;
            chk("frame_bit",    bus_a.tx_bit,     fr[12-i]);
            chk("frame_active", bus_a.tx_active,  1);
            chk("frame_done",   bus_a.frame_done, (i == 12));
            chk("frame_busy",   bus_a.in_ready,   0);
            if (i <= 4) chk("detector", det, (i == 4));
            bus_a.in_data = 8'($urandom);
        end
        for (int j = 1; j <= 2; j++) begin
            tick();
            chk("gap_bit",    bus_a.tx_bit,     0);
            chk("gap_active", bus_a.tx_active,  0);
            chk("gap_done",   bus_a.frame_done, 0);
            chk("gap_busy",   bus_a.in_ready,   0);
        end
        tick();
        chk("idle_ready",  bus_a.in_ready,  1);
        chk("idle_active", bus_a.tx_active, 0);
    endtask

    initial begin
        logic [11:0] fr;
        logic [6:0]  fb;
        bit          hold;

        // Reset held two cycles with a word offered
        rst = 1'b1;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 8'hA5;
        bus_b.in_valid = 1'b0;
        bus_b.in_data  = 4'h0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_bit",    bus_a.tx_bit,     0);
            chk("rst_active", bus_a.tx_active,  0);
            chk("rst_done",   bus_a.frame_done, 0);
            chk("rst_ready",  bus_a.in_ready,   1);
            chk("rst_b_ready", bus_b.in_ready,  1);
            chk("rst_b_active", bus_b.tx_active, 0);
        end
        rst = 1'b0;
        bus_a.in_valid = 1'b0;
        tick();
        chk("post_rst_active", bus_a.tx_active, 0);
        chk("post_rst_ready",  bus_a.in_ready,  1);

        // Single frame of A5
        do_frame(8'hA5, 1'b0);

        // Back-to-back with valid held: FF then 00
        do_frame(8'hFF, 1'b1);
        do_frame(8'h00, 1'b1);
        bus_a.in_valid = 1'b0;
        tick();
        chk("b2b_idle", bus_a.tx_active, 0);

        // Reset on the fifth frame bit of 3C
        fr = frame_of(8'h3C);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 8'h3C;
        for (int i = 1; i <= 5; i++) begin
            tick();
            bus_a.in_valid = 1'b0;
            chk("abort_bit", bus_a.tx_bit, fr[12-i]);
        end
        rst = 1'b1;
        tick();
        chk("abort_bit0",   bus_a.tx_bit,     0);
        chk("abort_active", bus_a.tx_active,  0);
        chk("abort_ready",  bus_a.in_ready,   1);
        chk("abort_done",   bus_a.frame_done, 0);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("abort_idle", bus_a.tx_active, 0);
        end
        do_frame(8'($urandom), 1'b0);

        // Narrow variant: 4-bit payload, no parity, no gap, valid held
        fb = {3'b101, 4'b1001};
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = 4'b1001;
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i <= 7; i++) begin
                tick();
                chk("nar_bit",    bus_b.tx_bit,     fb[7-i]);
                chk("nar_active", bus_b.tx_active,  1);
                chk("nar_done",   bus_b.frame_done, (i == 7));
                chk("nar_busy",   bus_b.in_ready,   0);
            end
            tick();
            chk("nar_ready",  bus_b.in_ready,  1);
            chk("nar_idle",   bus_b.tx_active, 0);
            chk("nar_idle_bit", bus_b.tx_bit,  0);
        end
        bus_b.in_valid = 1'b0;
        tick();
        chk("nar_stop", bus_b.tx_active, 0);

        // Random words through the detector loopback
        for (int n = 0; n < 200; n++) begin
            hold = 1'($urandom_range(0, 1));
            do_frame(8'($urandom), hold);
            if (!hold) begin
                for (int k = $urandom_range(0, 2); k > 0; k--) begin
                    tick();
                    chk("rand_idle", bus_a.in_ready, 1);
                end
            end
        end
        bus_a.in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
